// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmit arbiter: the line terminator that ends a
// lock, and the two-state lock FSM encoding.
package uart_pkg;

  localparam logic [7:0] NEWLINE = 8'h0A;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin first-one search: the lowest requester index at or after i_start, wrapping.
// Purely combinational; o_found is low when nobody is requesting.
module uart_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_start,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);

  logic [IW-1:0] cand;

  // Walk from the farthest candidate back to i_start so the nearest hit wins.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    cand    = '0;
    for (int j = N - 1; j >= 0; j--) begin
      cand = IW'((int'(i_start) + j) % N);
      if (i_req[cand]) begin
        o_idx   = cand;
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Line-locking round-robin arbiter: N_REQ byte sources share one UART transmitter.
// Latency 1 (accept -> o_tx_valid); owner is stalled while a held byte waits on i_tx_ready.
module uart_tx_arb #(
  parameter int N_REQ    = 4,
  parameter int IDLE_TMO = 1024
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [N_REQ-1:0]           i_req_valid,
  input  logic [N_REQ*8-1:0]         i_req_data,
  output logic [N_REQ-1:0]           o_req_ready,
  output logic                       o_tx_valid,
  output logic [7:0]                 o_tx_data,
  input  logic                       i_tx_ready,
  output logic [$clog2(N_REQ)-1:0]   o_grant_id,
  output logic                       o_busy
);
  import uart_pkg::*;

  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(IDLE_TMO + 1);

  arb_state_e    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tx_vld_q, tx_vld_d;
  logic [7:0]    tx_dat_q, tx_dat_d;

  logic [GW-1:0] pick_idx;
  logic          pick_found;
  logic          owner_vld;
  logic [7:0]    owner_dat;
  logic          accept;
  logic          lock_rel;

  uart_rr_pick #(
    .N  (N_REQ),
    .IW (GW)
  ) u_pick (
    .i_req   (i_req_valid),
    .i_start (rr_ptr_q),
    .o_idx   (pick_idx),
    .o_found (pick_found)
  );

  assign owner_vld = i_req_valid[grant_q];
  assign owner_dat = i_req_data[{grant_q, 3'b000} +: 8];
  assign accept    = (state_q == ST_LOCK) && owner_vld && (!tx_vld_q || i_tx_ready);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    tmo_cnt_d   = tmo_cnt_q;
    tx_vld_d    = tx_vld_q;
    tx_dat_d    = tx_dat_q;
    o_req_ready = '0;
    lock_rel    = 1'b0;

    // The output register drains on its own, independent of who holds the lock.
    if (accept) begin
      o_req_ready[grant_q] = 1'b1;
      tx_vld_d             = 1'b1;
      tx_dat_d             = owner_dat;
    end else if (i_tx_ready) begin
      tx_vld_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d   = pick_idx;
          state_d   = ST_LOCK;
          tmo_cnt_d = '0;
        end
      end
      ST_LOCK: begin
        if (accept) begin
          tmo_cnt_d = '0;
          lock_rel  = (owner_dat == NEWLINE);
        end else if (tmo_cnt_q == CW'(IDLE_TMO - 1)) begin
          lock_rel = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (lock_rel) begin
      state_d   = ST_IDLE;
      tmo_cnt_d = '0;
      rr_ptr_d  = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      tmo_cnt_q <= '0;
      tx_vld_q  <= 1'b0;
      tx_dat_q  <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      tmo_cnt_q <= tmo_cnt_d;
      tx_vld_q  <= tx_vld_d;
      tx_dat_q  <= tx_dat_d;
    end
  end

  assign o_tx_valid = tx_vld_q;
  assign o_tx_data  = tx_dat_q;
  assign o_grant_id = grant_q;
  assign o_busy     = (state_q == ST_LOCK);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: queue-driven requesters, a cycle model of the arbitration rules
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_uart_tx_arb;

  localparam int NR  = 4;
  localparam int GW  = 2;
  localparam int TMO = 16;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*8-1:0]   req_data;
  logic [NR-1:0]     req_ready;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic [GW-1:0]     grant_id;
  logic              busy;

  uart_tx_arb #(
    .N_REQ    (NR),
    .IDLE_TMO (TMO)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .o_req_ready (req_ready),
    .o_tx_valid  (tx_valid),
    .o_tx_data   (tx_data),
    .i_tx_ready  (tx_ready),
    .o_grant_id  (grant_id),
    .o_busy      (busy)
  );

  typedef struct {
    logic [7:0] b;
    logic       busy;
    int         cyc;
  } txrec_t;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  bit          rst_req  = 1'b1;
  bit          rand_en  = 1'b0;
  int          txr_mode = 0;
  logic [7:0]  src_q [NR][$];
  logic [NR-1:0] acc_seen = '0;
  txrec_t      tx_log [$];
  logic [7:0]  exp_q [$];

  // Behavioural model state
  bit          m_busy, m_v;
  logic [GW-1:0] m_own, m_ptr;
  int          m_sil;
  logic [7:0]  m_d;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d required below %0d", cyc, 200000);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Requester/transmitter driver: inputs change only on the falling edge.
  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    tx_ready  = 1'b0;
    forever begin
      @(negedge clk);
      rst_n = !rst_req;
      for (int k = 0; k < NR; k++)
        if (acc_seen[k] && src_q[k].size() != 0) void'(src_q[k].pop_front());
      for (int k = 0; k < NR; k++) begin
        logic v;
        v = (src_q[k].size() != 0);
        if (rand_en && $urandom_range(3) == 0) v = 1'b0;
        req_valid[k]       = v;
        req_data[k*8 +: 8] = v ? src_q[k][0] : 8'($urandom_range(255));
      end
      case (txr_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ($urandom_range(3) != 0);
        default: tx_ready = 1'b0;
      endcase
      #3;
      acc_seen = rst_n ? req_ready : '0;
      if (rst_n && tx_valid && tx_ready) tx_log.push_back('{tx_data, busy, cyc});
    end
  end

  // Compare process: model of the arbitration rules, checked every cycle.
  initial begin
    logic [NR-1:0]   exp_rdy, s_vld;
    logic [NR*8-1:0] s_dat;
    logic            s_txr, acc, rel;
    logic [7:0]      ab;
    bit              fnd;
    m_busy = 0; m_v = 0; m_own = '0; m_ptr = '0; m_sil = 0; m_d = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        m_busy = 0; m_v = 0; m_own = '0; m_ptr = '0; m_sil = 0; m_d = '0;
      end
      exp_rdy = '0;
      if (rst_n && m_busy && req_valid[m_own] && (!m_v || tx_ready)) exp_rdy[m_own] = 1'b1;
      chk("model_req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("model_tx_valid", 32'(tx_valid), 32'(m_v));
      if (m_v || !rst_n) chk("model_tx_data", 32'(tx_data), 32'(m_d));
      chk("model_grant_id", 32'(grant_id), 32'(m_own));
      chk("model_busy", 32'(busy), 32'(m_busy));
      s_vld = req_valid;
      s_dat = req_data;
      s_txr = tx_ready;
      @(posedge clk);
      if (rst_n) begin
        acc = (exp_rdy != '0);
        ab  = s_dat[m_own*8 +: 8];
        rel = 1'b0;
        if (acc) begin
          m_v = 1'b1;
          m_d = ab;
        end else if (s_txr) begin
          m_v = 1'b0;
        end
        if (!m_busy) begin
          fnd = 0;
          for (int j = 0; j < NR; j++) begin
            int idx;
            idx = (int'(m_ptr) + j) % NR;
            if (!fnd && s_vld[idx]) begin
              fnd    = 1;
              m_own  = GW'(idx);
              m_busy = 1;
              m_sil  = 0;
            end
          end
        end else if (acc) begin
          m_sil = 0;
          rel   = (ab == 8'h0A);
        end else begin
          m_sil++;
          rel = (m_sil == TMO);
        end
        if (rel) begin
          m_busy = 0;
          m_sil  = 0;
          m_ptr  = GW'((int'(m_own) + 1) % NR);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #4;
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < NR; k++) if (src_q[k].size() != 0) return 0;
    return 1;
  endfunction

  task automatic wait_idle(input string tag, input int budget);
    int n;
    bit done;
    n    = 0;
    done = 0;
    while (!done && n < budget) begin
      step();
      n++;
      done = all_empty() && !busy && !tx_valid;
    end
    chk({tag, "_drained"}, 32'(done), 32'd1);
  endtask

  task automatic rst_checks(input string tag);
    chk({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    chk({tag, "_tx_data"},  32'(tx_data),  32'd0);
    chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_req_ready"},32'(req_ready),32'd0);
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    step();
    rst_checks("rst");
    step();
    rst_req = 1'b0;
    step();
  endtask

  task automatic check_log(input string tag, input int base);
    chk({tag, "_len"}, 32'(tx_log.size() - base), 32'(exp_q.size()));
    foreach (exp_q[i])
      chk($sformatf("%s_byte%0d", tag, i),
          (base + i < tx_log.size()) ? 32'(tx_log[base + i].b) : 32'hFFFF_FFFF,
          32'(exp_q[i]));
  endtask

  task automatic push_line(input int k);
    int len;
    len = $urandom_range(5, 1);
    for (int i = 0; i < len - 1; i++) src_q[k].push_back(8'($urandom_range(255)));
    src_q[k].push_back(($urandom_range(3) != 0) ? 8'h0A : 8'($urandom_range(8'h7E, 8'h20)));
  endtask

  initial begin
    int base, ca, fall, gid_after, busy_after, seen, na;

    do_reset();

    // Single line "Hi\n" from requester 1, transmitter always ready.
    base = tx_log.size();
    src_q[1] = '{8'h48, 8'h69, 8'h0A};
    wait_idle("hi", 60);
    exp_q = '{8'h48, 8'h69, 8'h0A};
    check_log("hi", base);
    if (tx_log.size() >= base + 3) begin
      chk("hi_busy_b0",  32'(tx_log[base].busy),     32'd1);
      chk("hi_busy_b1",  32'(tx_log[base + 1].busy), 32'd1);
      chk("hi_busy_nl",  32'(tx_log[base + 2].busy), 32'd0);
      chk("hi_gap01", 32'(tx_log[base + 1].cyc - tx_log[base].cyc), 32'd1);
      chk("hi_gap12", 32'(tx_log[base + 2].cyc - tx_log[base + 1].cyc), 32'd1);
    end
    chk("hi_grant_id", 32'(grant_id), 32'd1);
    chk("hi_model_ptr", 32'(m_ptr), 32'd2);

    // Requesters 0 and 2 contend from reset: 0 first, lines unmixed.
    do_reset();
    base = tx_log.size();
    src_q[0] = '{8'hA0, 8'hA1, 8'h0A};
    src_q[2] = '{8'hB0, 8'hB1, 8'h0A};
    wait_idle("rr", 80);
    exp_q = '{8'hA0, 8'hA1, 8'h0A, 8'hB0, 8'hB1, 8'h0A};
    check_log("rr", base);
    chk("rr_grant_id", 32'(grant_id), 32'd2);

    // Owner 3 goes silent after one byte; timeout hands the line to waiting requester 1.
    base = tx_log.size();
    src_q[3] = '{8'h41};
    src_q[1] = '{8'hC1, 8'h0A};
    ca = -1; fall = -1; gid_after = -1; busy_after = -1;
    for (int n = 0; n < 80 && busy_after < 0; n++) begin
      step();
      if (fall >= 0 && cyc == fall + 1) begin
        gid_after  = grant_id;
        busy_after = busy;
      end
      if (req_ready[3]) ca = cyc;
      if (ca >= 0 && fall < 0 && !busy) fall = cyc;
    end
    chk("tmo_release_gap", 32'(fall - ca), 32'd17);
    chk("tmo_next_grant", 32'(gid_after), 32'd1);
    chk("tmo_next_busy", 32'(busy_after), 32'd1);
    wait_idle("tmo", 60);
    exp_q = '{8'h41, 8'hC1, 8'h0A};
    check_log("tmo", base);

    // Transmitter stalls with 55 held in the output register.
    base = tx_log.size();
    txr_mode = 2;
    src_q[2] = '{8'h55, 8'h56, 8'h0A};
    seen = 0;
    for (int n = 0; n < 20 && seen == 0; n++) begin
      step();
      if (tx_valid) seen = 1;
    end
    chk("hold_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_tx_valid", 32'(tx_valid), 32'd1);
      chk("hold_tx_data", 32'(tx_data), 32'h55);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    txr_mode = 0;
    wait_idle("hold", 40);
    exp_q = '{8'h55, 8'h56, 8'h0A};
    check_log("hold", base);

    // Reset in the middle of requester 2's line; requester 0 wins afterwards.
    src_q[2] = '{8'h31, 8'h32, 8'h33, 8'h0A};
    na = 0;
    for (int n = 0; n < 30 && na < 2; n++) begin
      step();
      if (req_ready[2]) na++;
    end
    chk("mid_accepts", 32'(na), 32'd2);
    src_q[0] = '{8'hD0, 8'h0A};
    rst_req = 1'b1;
    step();
    rst_checks("midrst");
    base = tx_log.size();
    rst_req = 1'b0;
    step();
    step();
    chk("midrst_next_grant", 32'(grant_id), 32'd0);
    chk("midrst_next_busy", 32'(busy), 32'd1);
    wait_idle("midrst", 60);
    exp_q = '{8'hD0, 8'h0A, 8'h33, 8'h0A};
    check_log("midrst", base);

    // Random traffic: valid gaps, transmitter stalls, unterminated lines, one reset.
    rand_en  = 1'b1;
    txr_mode = 1;
    for (int n = 0; n < 3000; n++) begin
      step();
      if (n == 1500) rst_req = 1'b1;
      if (n == 1502) rst_req = 1'b0;
      for (int k = 0; k < NR; k++)
        if (src_q[k].size() == 0 && $urandom_range(5) == 0) push_line(k);
    end
    rand_en  = 1'b0;
    txr_mode = 0;
    wait_idle("rand", 600);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of byte requesters sharing one UART transmitter (2..8).
REQ-002 SHALL have parameter IDLE_TMO, default 1024, owner-silent cycles before forced release (>=2).
REQ-003 SHALL have port i_clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_req_valid  input  N_REQ  per-requester byte valid.
REQ-006 SHALL have port i_req_data  input  N_REQ*8  per-requester byte, requester k at bits [8k+7:8k].
REQ-007 SHALL have port o_req_ready  output  N_REQ  per-requester byte accept, at most one bit high per cycle.
REQ-008 SHALL have port o_tx_valid  output  1  byte valid toward UART transmitter.
REQ-009 SHALL have port o_tx_data  output  8  byte toward UART transmitter.
REQ-010 SHALL have port i_tx_ready  input  1  transmitter accepts byte.
REQ-011 SHALL have port o_grant_id  output  $clog2(N_REQ)  current or last owner index.
REQ-012 SHALL have port o_busy  output  1  high while a line lock is held.

Function
REQ-013 SHALL implement FSM states IDLE and LOCK; o_busy = (state==LOCK).
REQ-014 SHALL, in IDLE with any i_req_valid high, pick the first requesting index at or after rr_ptr (wrapping modulo N_REQ), load o_grant_id, enter LOCK next cycle; no byte accepted in the IDLE cycle.
REQ-015 SHALL, in LOCK, assert o_req_ready[o_grant_id] combinationally when i_req_valid[o_grant_id] && (!o_tx_valid || i_tx_ready); all other ready bits low.
REQ-016 SHALL capture the accepted byte into the output register on that edge; o_tx_valid high the following cycle (latency 1), back-to-back throughput 1 byte/cycle.
REQ-017 SHALL hold o_tx_valid and o_tx_data stable until i_tx_ready is sampled high; clear o_tx_valid on that edge unless a new byte is captured simultaneously.
REQ-018 SHALL release the lock (LOCK->IDLE) on the edge accepting byte 8'h0A from the owner; that byte is still transmitted.
REQ-019 SHALL count consecutive LOCK cycles with no owner accept; reset the count on every accept; release the lock when count reaches IDLE_TMO.
REQ-020 SHALL set rr_ptr = (o_grant_id+1) mod N_REQ on every release; o_grant_id retains value in IDLE.
REQ-021 SHALL ignore non-owner requests during LOCK (they wait, no data loss).
REQ-022 SHALL let a pending output byte drain independently of release; a new owner's first accept obeys REQ-015.
REQ-023 SHALL, if owner valid drops mid-line, keep the lock until 8'h0A or timeout.

Reset
REQ-024 SHALL on i_rst_n low asynchronously force: state IDLE, o_tx_valid 0, o_tx_data 0, o_grant_id 0, rr_ptr 0, timeout count 0, o_req_ready 0.
REQ-025 SHALL discard any byte held in the output register on reset; a partial line is lost and no lock persists.

Structure
REQ-026 SHALL take the newline code 8'h0A and FSM state enum from shared package uart_pkg.
REQ-027 SHALL instantiate one sub-module uart_rr_pick (combinational round-robin first-one search from a start pointer, outputs index and found flag).

Verification
REQ-028 Single requester 1 sends "Hi\n" (48,69,0A), i_tx_ready=1 -> o_tx_data 48,69,0A on consecutive cycles, o_grant_id=1, o_busy falls after 0A accept.
REQ-029 Requesters 0 and 2 both valid from reset -> 0 granted first; after its 0A, 2 granted; both lines appear unmixed on o_tx_data.
REQ-030 Owner 3 sends 41 then goes silent, IDLE_TMO=16 -> release exactly 16 cycles after last accept, rr_ptr=0, waiting requester 1 granted next.
REQ-031 i_tx_ready low 5 cycles with byte 55 held -> o_tx_valid/o_tx_data stable 55, o_req_ready low, no capture, resumes on ready.
REQ-032 i_rst_n pulsed low mid-line of owner 2 -> outputs at reset values immediately, next grant chooses requester 0 if requesting.
